// File: rtl/pkmc_sdram_reqgen.sv
// Wishbone-to-SDRAM request generator: turns one Wishbone access into a single
// read/write command strobe, then tracks the controller's completion ack.
module pkmc_sdram_reqgen #(
  parameter int CAS_LAT = 2,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        ready_i,
  output logic        read_o,
  output logic        write_o,
  output logic [31:0] addr_o,
  output logic [3:0]  sel_o,
  input  logic        mem_ack_i,
  output logic        busy_o,
  output logic        lat_err_o,
  output logic        spur_o,
  input  logic        flag_clr_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [8:0] LAT_RD = 9'(CAS_LAT + 1);
  localparam logic [8:0] LAT_WR = 9'd1;
  localparam logic [8:0] TMO    = 9'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic        abort_q, abort_d;
  logic        lat_err_q, lat_err_d;
  logic        spur_q, spur_d;

  logic [8:0]  cnt_inc;
  logic [8:0]  exp_lat;
  logic        lat_set;
  logic        spur_set;

  // cnt_inc is the latency an ack seen in this WAIT cycle would represent.
  assign cnt_inc  = {1'b0, cnt_q} + 9'd1;
  assign exp_lat  = we_q ? LAT_WR : LAT_RD;
  assign spur_set = mem_ack_i && (state_q != S_WAIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    abort_d = abort_q;
    lat_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i && ready_i) begin
          addr_d  = wb_adr_i;
          sel_d   = wb_sel_i;
          we_d    = wb_we_i;
          abort_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
        if (!wb_cyc_i) abort_d = 1'b1;
      end
      S_WAIT: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        // An ack in the timeout cycle still completes the access normally.
        if (mem_ack_i) begin
          state_d = S_DONE;
          lat_set = (cnt_inc != exp_lat);
        end else if (cnt_inc == TMO) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign lat_err_d = lat_set  | (lat_err_q & ~flag_clr_i);
  assign spur_d    = spur_set | (spur_q    & ~flag_clr_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      sel_q     <= 4'd0;
      abort_q   <= 1'b0;
      lat_err_q <= 1'b0;
      spur_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      abort_q   <= abort_d;
      lat_err_q <= lat_err_d;
      spur_q    <= spur_d;
    end
  end

  // A cycle dropped mid-access stays silent even if the master re-opens cyc.
  assign read_o    = (state_q == S_ISSUE) && !we_q;
  assign write_o   = (state_q == S_ISSUE) &&  we_q;
  assign wb_ack_o  = (state_q == S_DONE) && wb_cyc_i && !abort_q;
  assign wb_err_o  = (state_q == S_ERR)  && wb_cyc_i && !abort_q;
  assign busy_o    = (state_q != S_IDLE);
  assign addr_o    = addr_q;
  assign sel_o     = sel_q;
  assign lat_err_o = lat_err_q;
  assign spur_o    = spur_q;

endmodule
